// File: rtl/loop_ctl_pkg.sv
// Shared types and constants for the loop-control state-register sequencer.
// The FB_CHECK_EN build option is consumed by loop_state_sequencer.
package loop_ctl_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned NSTATE = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DWELL  = 3'd4,
        ERR    = 3'd5
    } seq_state_e;

    function automatic logic [NSTATE-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [NSTATE-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/loop_seq_timer.sv
// Loadable down-counter shared by the PULSE, SETTLE and DWELL phases.
// Holds at zero until reloaded; o_zero flags the final cycle of a phase.
module loop_seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         por,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (por) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/loop_state_sequencer.sv
// Set/reset pulse sequencer stepping the SR-latch state register through codes 0..7.
// Define FB_CHECK_EN to compare the decoder one-hot feedback after each step.
module loop_state_sequencer
    import loop_ctl_pkg::*;
#(
    parameter int unsigned PULSE_W  = 2,
    parameter int unsigned SETTLE_W = 3,
    parameter int unsigned DWELL_W  = 8
) (
    input  logic                clk,
    input  logic                por,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [DWELL_W-1:0]  dwell_len,
    input  logic [NSTATE-1:0]   state_fb,
    output logic [CODE_W-1:0]   s,
    output logic [CODE_W-1:0]   r,
    output logic                latch_rb,
    output logic [CODE_W-1:0]   code,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned TW = max3(DWELL_W, $clog2(PULSE_W), $clog2(SETTLE_W));
    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NSTATE - 1);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] r_s;
    logic [CODE_W-1:0] r_r;
    logic              r_latch_rb;
    logic              r_done;
    logic              r_stop_seen;

    logic [CODE_W-1:0] w_code_inc;
    logic              w_step;
    logic              w_done;
    logic              w_pulse_end;
    logic              w_stop_any;
    logic              w_fb_bad;
    logic              w_tmr_load;
    logic [TW-1:0]     w_tmr_val;
    logic              w_tmr_zero;

    loop_seq_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .por        (por),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

`ifdef FB_CHECK_EN
    assign w_fb_bad = (state_fb != onehot8(r_code));
    assign err      = (r_state == ERR);
`else
    logic w_unused_fb;
    assign w_unused_fb = ^state_fb;
    assign w_fb_bad    = 1'b0;
    assign err         = 1'b0;
`endif

    assign w_code_inc  = r_code + CODE_W'(1);
    assign w_pulse_end = (r_state == PULSE) && w_tmr_zero;
    // A stop arriving on the very cycle DWELL expires still ends the run.
    assign w_stop_any  = r_stop_seen | stop;

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_done      = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        case (r_state)
            IDLE: begin
                if (start) w_step = 1'b1;
            end
            PULSE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = SETTLE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(SETTLE_W - 1);
                end
            end
            SETTLE: begin
                if (w_tmr_zero) w_state_nxt = CHECK;
            end
            CHECK: begin
                if (w_fb_bad) begin
                    w_state_nxt = ERR;
                end else begin
                    w_state_nxt = DWELL;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = (dwell_len == '0) ? '0 : TW'(dwell_len) - TW'(1);
                end
            end
            DWELL: begin
                if (w_tmr_zero) begin
                    if (w_stop_any) begin
                        w_state_nxt = IDLE;
                    end else if ((r_code == LAST_CODE) && !loop_en) begin
                        w_state_nxt = IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_step) begin
            w_state_nxt = PULSE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TW'(PULSE_W - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (por) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_s         <= '0;
            r_r         <= '0;
            r_latch_rb  <= 1'b0;
            r_done      <= 1'b0;
            r_stop_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_latch_rb <= 1'b1;
            r_done     <= w_done;
            if (w_state_nxt == IDLE) begin
                r_stop_seen <= 1'b0;
            end else if (stop && (r_state != ERR)) begin
                r_stop_seen <= 1'b1;
            end
            if (w_step) begin
                r_s <= w_code_inc & ~r_code;
                r_r <= r_code & ~w_code_inc;
            end else if (w_pulse_end) begin
                r_s    <= '0;
                r_r    <= '0;
                r_code <= w_code_inc;
            end
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign latch_rb = r_latch_rb;
    assign code     = r_code;
    assign busy     = (r_state != IDLE) && (r_state != ERR);
    assign done     = r_done;

endmodule

// File: tb/tb_loop_state_sequencer.sv
// Directed plus randomized bench for loop_state_sequencer with a timeline reference model.
// The feedback-error scenario runs only when FB_CHECK_EN is defined.
module tb_loop_state_sequencer;

    localparam int unsigned PW = 2;
    localparam int unsigned SW = 3;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          por;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [DW-1:0] dwell_len;
    logic [7:0]    state_fb;
    logic [2:0]    s;
    logic [2:0]    r;
    logic          latch_rb;
    logic [2:0]    code;
    logic          busy;
    logic          done;
    logic          err;

    logic          fb_force;
    logic [7:0]    fb_val;

    int n_tests = 0;
    int n_fail  = 0;
    int cur;

    always #5 clk = ~clk;

    // Behaves like the decoder unless a scenario forces a broken feedback value.
    always_comb state_fb = fb_force ? fb_val : (8'h01 << code);

    loop_state_sequencer #(
        .PULSE_W  (PW),
        .SETTLE_W (SW),
        .DWELL_W  (DW)
    ) dut (
        .clk       (clk),
        .por       (por),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .dwell_len (dwell_len),
        .state_fb  (state_fb),
        .s         (s),
        .r         (r),
        .latch_rb  (latch_rb),
        .code      (code),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input int es, input int er, input int ec,
                             input int eb, input int ed, input int ee, input int elrb);
        chk({tag, ".s"},        8'(s),        8'(es));
        chk({tag, ".r"},        8'(r),        8'(er));
        chk({tag, ".code"},     8'(code),     8'(ec));
        chk({tag, ".busy"},     8'(busy),     8'(eb));
        chk({tag, ".done"},     8'(done),     8'(ed));
        chk({tag, ".err"},      8'(err),      8'(ee));
        chk({tag, ".latch_rb"}, 8'(latch_rb), 8'(elrb));
    endtask

    // Bits that must go 0->1 (set) and 1->0 (reset) when moving from a to b.
    function automatic int set_bits(input int a, input int b);
        int m;
        m = 0;
        for (int i = 0; i < 3; i++)
            if (((b >> i) & 1) == 1 && ((a >> i) & 1) == 0) m += (1 << i);
        return m;
    endfunction

    function automatic int rst_bits(input int a, input int b);
        return set_bits(b, a);
    endfunction

    // One step as a timeline: PW pulse cycles, then SW settle + 1 check + max(d,1) dwell cycles.
    task automatic run_step(input int c0, input int d, input int dnew, input int stop_k,
                            input bit rnd_start, output bit stopped);
        int nx;
        int p;
        nx      = (c0 + 1) % 8;
        p       = PW + SW + 1 + ((d == 0) ? 1 : d);
        stopped = 1'b0;
        for (int k = 0; k < p; k++) begin
            if (k < PW) check_all("pulse", set_bits(c0, nx), rst_bits(c0, nx), c0, 1, 0, 0, 1);
            else        check_all("gap", 0, 0, nx, 1, 0, 0, 1);
            stop = (k == stop_k);
            if (k == stop_k) stopped = 1'b1;
            start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
            if (k == int'(PW + SW + 1)) dwell_len = DW'(dnew);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic finish_run(input int c, input int exp_done);
        check_all("end", 0, 0, c, 0, exp_done, 0, 1);
        @(negedge clk);
        check_all("idle", 0, 0, c, 0, 0, 0, 1);
    endtask

    task automatic do_run(input int c0, input bit le, input int stop_step, input int stop_k,
                          input bit rnd, input bit ss, input int d0, output int c_out);
        int  c;
        int  d;
        int  dn;
        bit  st;
        bit  stopped_any;
        bit  ended;
        loop_en   = le;
        dwell_len = DW'(d0);
        start     = 1'b1;
        stop      = ss;
        @(negedge clk);
        start       = 1'b0;
        stop        = 1'b0;
        c           = c0;
        d           = d0;
        stopped_any = ss;
        ended       = 1'b0;
        for (int n = 0; n < 16 && !ended; n++) begin
            dn = rnd ? int'($urandom_range(0, 6)) : d;
            run_step(c, d, dn, (n == stop_step) ? stop_k : -1, rnd, st);
            stopped_any |= st;
            c = (c + 1) % 8;
            d = dn;
            if (stopped_any) begin
                finish_run(c, 0);
                ended = 1'b1;
            end else if (c == 7 && !le) begin
                finish_run(c, 1);
                ended = 1'b1;
            end
        end
        chk("run_ended", 8'(ended), 8'd1);
        c_out = c;
    endtask

    initial begin
        por       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        loop_en   = 1'b0;
        dwell_len = '0;
        fb_force  = 1'b0;
        fb_val    = 8'h00;

        // Reset and release
        repeat (3) @(negedge clk);
        check_all("por", 0, 0, 0, 0, 0, 0, 0);
        por = 1'b0;
        @(negedge clk);
        check_all("release", 0, 0, 0, 0, 0, 0, 1);

        // Full climb 0..7 with no dwell, halting with done
        do_run(0, 1'b0, -1, -1, 1'b0, 1'b0, 0, cur);
        chk("climb_code", 8'(code), 8'd7);

        // Looping with dwell 5 from code 7 (wrap first), stop mid-PULSE of step 2->3
        do_run(7, 1'b1, 3, 0, 1'b0, 1'b0, 5, cur);
        chk("stop_code", 8'(cur), 8'd3);
        repeat (5) begin
            @(negedge clk);
            check_all("quiet", 0, 0, 3, 0, 0, 0, 1);
        end

        // start and stop together: exactly one step even with looping enabled
        do_run(cur, 1'b1, -1, -1, 1'b0, 1'b1, 2, cur);
        chk("ss_code", 8'(cur), 8'd4);

        // Randomized runs
        for (int t = 0; t < 20; t++) begin
            int gap;
            bit le;
            int sstep;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                stop = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_all("gap_idle", 0, 0, cur, 0, 0, 0, 1);
            end
            stop  = 1'b0;
            le    = 1'($urandom_range(0, 1));
            sstep = le ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 12));
            do_run(cur, le, sstep, int'($urandom_range(0, PW + SW + 1)), 1'b1,
                   1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 6)), cur);
        end

        // por asserted during PULSE
        loop_en   = 1'b0;
        dwell_len = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_all("pre_por", set_bits(cur, (cur + 1) % 8), rst_bits(cur, (cur + 1) % 8),
                  cur, 1, 0, 0, 1);
        por = 1'b1;
        @(negedge clk);
        check_all("midpor", 0, 0, 0, 0, 0, 0, 0);
        por = 1'b0;
        @(negedge clk);
        check_all("midpor_rel", 0, 0, 0, 0, 0, 0, 1);
        do_run(0, 1'b0, 0, 3, 1'b0, 1'b0, 1, cur);
        chk("post_por_code", 8'(cur), 8'd1);

`ifdef FB_CHECK_EN
        // Stuck feedback during step 0->1 lands in ERR
        por = 1'b1;
        repeat (2) @(negedge clk);
        por      = 1'b0;
        @(negedge clk);
        fb_force = 1'b1;
        fb_val   = 8'h01;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= int'(PW + SW); k++) begin
            if (k < int'(PW)) check_all("fb_pulse", 1, 0, 0, 1, 0, 0, 1);
            else              check_all("fb_gap", 0, 0, 1, 1, 0, 0, 1);
            @(negedge clk);
        end
        check_all("fb_err", 0, 0, 1, 0, 0, 1, 1);
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all("fb_sticky", 0, 0, 1, 0, 0, 1, 1);
        end
        start    = 1'b0;
        fb_force = 1'b0;
        por      = 1'b1;
        @(negedge clk);
        check_all("fb_por", 0, 0, 0, 0, 0, 0, 0);
        por = 1'b0;
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
